// File: rtl/reaction_game_pkg.sv
// reaction_game_pkg: shared FSM states, target modes, LFSR and 7-segment constants
package reaction_game_pkg;
  localparam logic [1:0] WAIT = 2'd0, SHOW = 2'd1, COOL = 2'd2;
  localparam int MODE_WALK = 0, MODE_LFSR = 1;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // right-shifting Fibonacci taps at bits 0,2,3,5 give x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  // active-low {a..g}; codes above 9 blank the digit
  localparam logic [15:0][6:0] SEG7 = {{6{7'h7f}},
    7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
    7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001};
endpackage

// File: rtl/reaction_game_if.sv
// reaction_game_if: keys, LEDs, judge pulses, score and display lines of the game core
interface reaction_game_if #(parameter int CHANNELS = 4, parameter int DIGITS = 2);
  logic [CHANNELS-1:0] key_in, led_out;
  logic hit, miss;
  logic [4*DIGITS-1:0] score;
  logic [DIGITS-1:0] select_out;
  logic [6:0] segment_out;
  modport master(output key_in, input led_out, hit, miss, score, select_out, segment_out);
  modport slave(input key_in, output led_out, hit, miss, score, select_out, segment_out);
endinterface

// File: rtl/reaction_game_key_debounce.sv
// key_debounce: per-channel counters accepting a key state after DEBOUNCE equal samples
module key_debounce #(
  parameter int CHANNELS = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_i,
  input  logic [CHANNELS-1:0] key_i,
  output logic [CHANNELS-1:0] db_o,
  output logic [CHANNELS-1:0] rise_o
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [CHANNELS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0] db_q, db_d, rise_q;
  always_comb begin
    cnt_d = cnt_q;
    db_d = db_q;
    for (int i = 0; i < CHANNELS; i++)
      if (tick_i) begin
        cnt_d[i] = key_i[i] == db_q[i] || cnt_q[i] == CW'(DEBOUNCE - 1) ? '0 : cnt_q[i] + 1'b1;
        db_d[i] = db_q[i] ^ (key_i[i] != db_q[i] && cnt_q[i] == CW'(DEBOUNCE - 1));
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      db_q <= '0;
      rise_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      db_q <= db_d;
      rise_q <= db_d & ~db_q;
    end
  assign db_o = db_q;
  assign rise_o = rise_q;
endmodule

// File: rtl/reaction_game.sv
// reaction_game: tick-enabled reaction game with judge FSM, BCD score and multiplexed 7-segment display
module reaction_game import reaction_game_pkg::*; #(
  parameter int CHANNELS    = 4,
  parameter int DIGITS      = 2,
  parameter int STEP_DIV    = 2**24,
  parameter int SCAN_DIV    = 2**20,
  parameter int REFRESH_DIV = 2**15,
  parameter int DEBOUNCE    = 3,
  parameter int MODE        = MODE_WALK
) (
  input logic clk_in,
  input logic clr,
  reaction_game_if.slave bus
);
  localparam int SW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam int KW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(CHANNELS);
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [SW-1:0] step_q;
  logic [KW-1:0] scan_q;
  logic [RW-1:0] ref_q;
  logic step_tick, scan_tick, ref_tick;
  logic [CHANNELS-1:0] db, rise, risen;
  logic [1:0] state_q, state_d;
  logic [IW-1:0] tgt_q, tgt_d, walk, rnd;
  logic [15:0] lfsr_q, lfsr_d;
  logic hit_q, hit_d, miss_q, miss_d, good, carry;
  logic [4*DIGITS-1:0] score_q, score_d, bcd_inc;
  logic [DW-1:0] dig_q, dig_d;
  logic [DIGITS-1:0] sel_q;
  logic [6:0] seg_q;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return i == IW'(CHANNELS - 1) ? '0 : i + 1'b1;
  endfunction

  assign step_tick = step_q == SW'(STEP_DIV - 1);
  assign scan_tick = scan_q == KW'(SCAN_DIV - 1);
  assign ref_tick = ref_q == RW'(REFRESH_DIV - 1);

  key_debounce #(.CHANNELS(CHANNELS), .DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk(clk_in), .rst(clr), .tick_i(scan_tick), .key_i(bus.key_in), .db_o(db), .rise_o(rise)
  );

  always_comb begin
    risen = rise & db;
    lfsr_d = step_tick ? {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]} : lfsr_q;
    rnd = IW'(lfsr_d % 16'(CHANNELS));
    walk = state_q == WAIT ? '0 : next_idx(tgt_q);
    good = risen == (CHANNELS'(1) << tgt_q);
    // a press judged together with a step tick still lands in SHOW on the new target
    hit_d = state_q == SHOW && |risen && good;
    miss_d = state_q == SHOW && (|risen ? !good : step_tick);
    state_d = step_tick ? SHOW : hit_d || miss_d ? COOL : state_q;
    tgt_d = !step_tick ? tgt_q : MODE == MODE_LFSR ? (rnd == tgt_q ? next_idx(rnd) : rnd) : walk;
    carry = 1'b1;
    bcd_inc = score_q;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_inc[4*i +: 4] = carry ? (score_q[4*i +: 4] == 4'd9 ? 4'd0 : score_q[4*i +: 4] + 4'd1) : score_q[4*i +: 4];
      carry = carry && score_q[4*i +: 4] == 4'd9;
    end
    score_d = hit_d ? bcd_inc : score_q;
    dig_d = dig_q == DW'(DIGITS - 1) ? '0 : dig_q + 1'b1;
  end

  always_ff @(posedge clk_in)
    if (clr) begin
      step_q <= '0;
      scan_q <= '0;
      ref_q <= '0;
      state_q <= WAIT;
      tgt_q <= '0;
      lfsr_q <= LFSR_SEED;
      hit_q <= 1'b0;
      miss_q <= 1'b0;
      score_q <= '0;
      dig_q <= '0;
      sel_q <= ~DIGITS'(1);
      seg_q <= SEG7[0];
    end else begin
      step_q <= step_tick ? '0 : step_q + 1'b1;
      scan_q <= scan_tick ? '0 : scan_q + 1'b1;
      ref_q <= ref_tick ? '0 : ref_q + 1'b1;
      state_q <= state_d;
      tgt_q <= tgt_d;
      lfsr_q <= lfsr_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
      score_q <= score_d;
      if (ref_tick) begin
        dig_q <= dig_d;
        sel_q <= ~(DIGITS'(1) << dig_d);
        seg_q <= SEG7[score_q[4*dig_d +: 4]];
      end
    end

  assign bus.led_out = state_q == SHOW ? (CHANNELS'(1) << tgt_q) : '0;
  assign bus.hit = hit_q;
  assign bus.miss = miss_q;
  assign bus.score = score_q;
  assign bus.select_out = sel_q;
  assign bus.segment_out = seg_q;
endmodule

// File: tb/tb_reaction_game.sv
// tb_reaction_game: randomized key play against a rule-level model of the reaction game
module tb_reaction_game;
  localparam int CH = 4, DG = 2, STEP = 64, SCAN = 4, REF = 8, DEB = 2;
  logic clk = 1'b0, clr = 1'b1;
  int n_vec = 0, n_bad = 0;
  int c, m_tgt, m_score, m_hits = 0, m_refs, m_pos, m_val;
  bit m_started, m_lit, e_hit, e_miss;
  logic [CH-1:0] m_db, m_pend;
  logic [CH-1:0] smp[$];
  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  always #5 clk = ~clk;

  reaction_game_if #(.CHANNELS(CH), .DIGITS(DG)) bus ();

  reaction_game #(.CHANNELS(CH), .DIGITS(DG), .STEP_DIV(STEP), .SCAN_DIV(SCAN),
                  .REFRESH_DIV(REF), .DEBOUNCE(DEB), .MODE(0)) dut (
    .clk_in(clk), .clr(clr), .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  task automatic model_step();
    logic [CH-1:0] rise;
    bit all;
    if (clr) begin
      c = 0; m_started = 0; m_lit = 0; m_tgt = 0; m_score = 0; m_db = '0; m_pend = '0;
      smp.delete(); m_refs = 0; m_pos = 0; m_val = 0; e_hit = 0; e_miss = 0;
      return;
    end
    rise = '0;
    e_hit = 0;
    e_miss = 0;
    if (c % REF == REF - 1) begin
      m_refs++;
      m_pos = m_refs % DG;
      m_val = (m_score / (10 ** m_pos)) % 10;
    end
    if (m_lit && m_pend != 0) begin
      e_hit = m_pend == CH'(1 << m_tgt);
      e_miss = !e_hit;
      m_lit = 0;
    end else if (m_lit && c % STEP == STEP - 1) e_miss = 1;
    if (c % STEP == STEP - 1) begin
      m_tgt = m_started ? (m_tgt + 1) % CH : 0;
      m_started = 1;
      m_lit = 1;
    end
    if (e_hit) begin
      m_score = (m_score + 1) % 100;
      m_hits++;
    end
    if (c % SCAN == SCAN - 1) begin
      smp.push_back(bus.key_in);
      if (smp.size() > DEB) void'(smp.pop_front());
      if (smp.size() == DEB)
        for (int i = 0; i < CH; i++) begin
          all = 1'b1;
          foreach (smp[j]) if (smp[j][i] == m_db[i]) all = 1'b0;
          if (all) begin
            m_db[i] = ~m_db[i];
            rise[i] = m_db[i];
          end
        end
    end
    m_pend = rise;
    c++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("led", bus.led_out, m_lit ? 1 << m_tgt : 0);
    chk("hit", bus.hit, e_hit);
    chk("miss", bus.miss, e_miss);
    chk("score", bus.score, (m_score / 10) * 16 + m_score % 10);
    chk("select", bus.select_out, ~(1 << m_pos) & ((1 << DG) - 1));
    chk("segment", bus.segment_out, seg_tab[m_val]);
    if (e_hit && m_hits == 99) chk("score_99", bus.score, 'h99);
    if (e_hit && m_hits == 100) chk("score_wrap", bus.score, 0);
  endtask

  initial begin
    logic [CH-1:0] k;
    int r, b, hold;
    bus.key_in = '0;
    repeat (3) cyc();
    chk("rst_led", bus.led_out, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_select", bus.select_out, 2'b10);
    chk("rst_segment", bus.segment_out, 7'b0000001);
    chk("rst_hit", bus.hit, 0);
    chk("rst_miss", bus.miss, 0);
    clr = 1'b0;
    repeat (STEP) cyc();
    chk("first_led", bus.led_out, 4'b0001);
    for (int p = 1; p <= 4; p++) begin
      repeat (STEP) cyc();
      chk("walk_led", bus.led_out, 1 << (p % CH));
      chk("walk_miss", bus.miss, 1);
    end
    for (int it = 0; it < 400 && m_hits < 101; it++) begin
      b = 0;
      while (!m_lit && b < 200) begin
        cyc();
        b++;
      end
      if (!m_lit) chk("lit_wait", 32'(m_lit), 1);
      repeat ($urandom_range(0, 6)) cyc();
      r = $urandom_range(0, 99);
      k = CH'(1 << m_tgt);
      hold = $urandom_range(8, 16);
      if (r >= 70 && r < 80) k = CH'(1 << ((m_tgt + $urandom_range(1, CH - 1)) % CH));
      else if (r >= 80 && r < 88) k = k | CH'(1 << ((m_tgt + $urandom_range(1, CH - 1)) % CH));
      else if (r >= 88 && r < 94) hold = $urandom_range(1, 3);
      else if (r >= 94) hold = 90;
      bus.key_in = k;
      repeat (hold) cyc();
      bus.key_in = '0;
      repeat (12) cyc();
    end
    if (m_hits < 101) chk("hit_budget", m_hits, 101);
    bus.key_in = 4'b0100;
    repeat (4) cyc();
    clr = 1'b1;
    repeat (3) cyc();
    clr = 1'b0;
    repeat (40) cyc();
    chk("held_reset_led", bus.led_out, 0);
    bus.key_in = '0;
    repeat (80) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/reaction_game.md
# reaction_game

Parametrised reaction-game core: lights one of CHANNELS LEDs per step period, judges debounced key presses against the lit LED, keeps a DIGITS-digit BCD hit score, and drives a multiplexed active-low 7-segment display. It replaces the fixed 4-LED/2-digit game in the top level. All timing comes from single-cycle clock enables on one clock, so the block has no derived clocks.

## Interface
- CHANNELS, 4: number of LED/key pairs (2..16)
- DIGITS, 2: BCD score digits and display positions (1..8)
- STEP_DIV, 2**24: clk_in cycles per LED step
- SCAN_DIV, 2**20: clk_in cycles per key sample
- REFRESH_DIV, 2**15: clk_in cycles per display digit advance
- DEBOUNCE, 3: consecutive equal key samples needed to accept a new key state
- MODE, 0: target order; 0 = walking index, 1 = LFSR random
- clk_in  input  1  system clock, the only clock
- clr  input  1  reset, synchronous, active-high
- key_in  input  CHANNELS  raw keys, 1 = pressed
- led_out  output  CHANNELS  one-hot target, or all 0
- hit  output  1  one-cycle pulse on a correct press
- miss  output  1  one-cycle pulse on a wrong press or a timeout
- score  output  4*DIGITS  BCD score; digit 0 (ones) is in the LSBs
- select_out  output  DIGITS  digit enable, active-low one-hot
- segment_out  output  7  segments {a,b,c,d,e,f,g}, with a at the MSB; active-low

## Operation
- **Tick generation.** Three free-running counters. Each counter asserts its tick for one cycle when it reaches DIV-1, then wraps to 0.
- **Debounce.** Sample key_in on each scan tick. A channel's debounced bit changes only after DEBOUNCE consecutive equal samples that differ from its current value.
- **Press event.** One or more debounced bits rise in a cycle. Holding a key never repeats the event.
- **States:** WAIT, SHOW, COOL.
  - **WAIT:** entered from reset. led_out = 0. Press events are ignored (no hit, no miss). A step tick loads the first target and moves to SHOW.
  - **SHOW:** led_out = one-hot(target).
    - Press event with exactly one risen bit equal to the target: hit; score increments; go to COOL.
    - Any other press event (wrong key, or more than one risen bit): miss; go to COOL.
    - Step tick with no press: miss (timeout); load the next target; stay in SHOW.
  - **COOL:** led_out = 0. Press events are ignored. A step tick loads the next target and moves to SHOW.
- **Press and step tick in the same cycle, in SHOW.** Judge the press against the current target, emit hit or miss, then load the next target and remain in SHOW.
- **Target, MODE 0.** Index advances 0,1,…,CHANNELS-1, then wraps to 0. The first target is 0.
- **Target, MODE 1.**
  - 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, seed 16'hACE1, stepped once per step tick.
  - Index = lfsr mod CHANNELS. If that equals the previous index, use (index+1) mod CHANNELS.
- **Score.** BCD ripple carry across all digits. All 9s + 1 wraps to all 0s with no flag.
- **Display.**
  - Digit pointer advances 0..DIGITS-1 on each refresh tick, wrapping to 0.
  - select_out bit i is low when digit i is shown; bit 0 is the ones digit.
  - segment_out encodes 0–9 as 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.

## Timing
- **Reset values:**
  - state WAIT; tick counters, debounce state, score and digit pointer all 0
  - led_out 0; hit 0; miss 0; score 0
  - select_out = all 1s except bit 0 = 0; segment_out = 0000001
  - LFSR = seed; MODE 0 index = 0
- **Key latency.** A key stable from a scan tick is accepted on the DEBOUNCE-th scan tick (counting that one). hit/miss and the new score are registered one cycle after that scan tick.
- **LED latency.** led_out updates one cycle after the step tick, or after the judging cycle when moving to COOL.
- **Display latency.** select_out and segment_out update together, one cycle after a refresh tick. Score changes appear at the next refresh of the affected digit.
- **Reset mid-game.** Reset overrides everything in the same cycle. A key held through reset is seen as a new press DEBOUNCE scan ticks later; it lands in WAIT and is ignored.
- hit and miss are never high in the same cycle.

## Structure
- **Package reaction_game_pkg:**
  - state enum {WAIT, SHOW, COOL}
  - MODE_WALK = 0, MODE_LFSR = 1
  - LFSR seed and tap constants
  - 7-segment code constants for 0–9
- **Sub-module key_debounce:** CHANNELS-wide sample counters. Outputs are the debounced vector and a registered rising-edge vector.
- The tick counters, FSM, score and display mux stay in reaction_game.

## Test plan
Bench parameters: STEP_DIV=64, SCAN_DIV=4, REFRESH_DIV=8, DEBOUNCE=2, CHANNELS=4, DIGITS=2.
- **Reset.** Assert clr for 3 cycles, then release.
  - Immediately after reset: led_out=0000, score=00, select_out=10 (bit 0 low), segment_out=0000001.
  - First step tick → led_out=0001.
- **MODE 0 walk, keys idle.** led_out steps 0001 → 0010 → 0100 → 1000 → 0001. A miss pulse occurs on every step tick after the first; score stays 00.
- **Correct press.** With target 0100, hold key_in=0100 for 3 scan ticks.
  - Exactly one hit; score goes 00 → 01; led_out=0000 until the next step tick.
  - A continued hold produces no further hits.
- **Wrong press, multi-key press, bounce.**
  - key_in=0011 pressed while target is 0010 → one miss, score unchanged.
  - A 1-scan-tick glitch → no event.
- **Score wrap.** 99 correct presses → score=99; the 100th → score=00.
- **Display mux.** With score=37: select_out=10 shows 0001111 ('7'); select_out=01 shows 0000110 ('3'). The display alternates on every refresh tick.
